// File: rtl/uart_ram_bridge_pkg.sv
// Shared types and constants for the UART-to-block-RAM command bridge.
package uart_ram_bridge_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_ADDR   = 4'd1,
    RX_CMD    = 4'd2,
    RX_DATA   = 4'd3,
    WRITE     = 4'd4,
    READ      = 4'd5,
    READ_WAIT = 4'd6,
    TX_HEADER = 4'd7,
    TX_DATA   = 4'd8,
    RX_CSUM   = 4'd9,
    TX_STATUS = 4'd10,
    TX_CSUM   = 4'd11
  } state_e;

  localparam int CMD_WRITE_BIT = 0;
  localparam int CMD_LEN_LSB   = 1;
  localparam int CMD_LEN_MSB   = 7;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'h55;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_ram_bridge_timeout_counter.sv
// Inter-byte receive watchdog: counts idle cycles while enabled, flags expiry.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every byte and whenever the watchdog is disarmed.
  always_comb begin
    if (!enable_i || clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (expired_o) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_ram_bridge.sv
// UART framed command stream to block-RAM bridge with burst read/write.
// Define UART_RAM_BRIDGE_CHECKSUM_EN for checksum validation and status replies.
module uart_ram_bridge
  import uart_ram_bridge_pkg::*;
#(
  parameter int ADDR_BYTES     = 1,
  parameter int DATA_BYTES     = 2,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    new_rx_data_i,
  input  logic [7:0]              rx_data_i,
  input  logic [7:0]              header_byte_i,
  input  logic                    tx_busy_i,
  output logic [7:0]              tx_data_o,
  output logic                    new_tx_data_o,
  output logic [8*ADDR_BYTES-1:0] ram_addr_o,
  output logic [8*DATA_BYTES-1:0] ram_wdata_o,
  output logic                    ram_we_o,
  output logic                    ram_re_o,
  input  logic [8*DATA_BYTES-1:0] ram_rdata_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam int DATA_W = 8 * DATA_BYTES;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [6:0]        count_q, count_d;
  logic [7:0]        idx_q, idx_d;
  logic [2:0]        lat_q, lat_d;
  logic [1:0]        guard_q, guard_d;
  logic              first_q, first_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_q, new_tx_d, we_q, we_d, re_q, re_d;
  logic              timeout_q, timeout_d, busy_q, busy_d;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              is_write_q, is_write_d, csum_ok_q, csum_ok_d;
`endif
  logic              in_rx_s, expired_s, tx_go_s;

  assign in_rx_s = state_q inside {RX_ADDR, RX_CMD, RX_DATA, RX_CSUM};
  // The guard counter covers the strobe cycle plus one cycle the transmitter needs to raise busy.
  assign tx_go_s = (guard_q == 2'd0) && !tx_busy_i;

  timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (new_rx_data_i),
    .enable_i (in_rx_s),
    .expired_o(expired_s)
  );

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    count_d   = count_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    first_d   = first_q;
    tx_data_d = tx_data_q;
    new_tx_d  = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    timeout_d = 1'b0;
    guard_d   = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
    csum_d     = csum_q;
    is_write_d = is_write_q;
    csum_ok_d  = csum_ok_q;
`endif
    if (in_rx_s && expired_s) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_rx_data_i && (rx_data_i == header_byte_i)) begin
            state_d = RX_ADDR;
            idx_d   = 8'd0;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        RX_ADDR: begin
          if (new_rx_data_i) begin
            addr_d[int'(idx_q)*8 +: 8] = rx_data_i;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
            csum_d = csum_update(csum_q, rx_data_i);
`endif
            if (idx_q == 8'(ADDR_BYTES - 1)) begin
              idx_d   = 8'd0;
              state_d = RX_CMD;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else begin
            state_d = RX_ADDR;
          end
        end
        RX_CMD: begin
          if (new_rx_data_i) begin
            count_d = rx_data_i[CMD_LEN_MSB:CMD_LEN_LSB];
            idx_d   = 8'd0;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
            is_write_d = rx_data_i[CMD_WRITE_BIT];
            csum_d     = rx_data_i[CMD_WRITE_BIT] ? csum_update(csum_q, rx_data_i) : 8'd0;
`endif
            if (rx_data_i[CMD_WRITE_BIT]) begin
              state_d = RX_DATA;
            end else begin
              state_d = READ;
              re_d    = 1'b1;
              lat_d   = 3'(RD_LATENCY - 1);
              first_d = 1'b1;
            end
          end else begin
            state_d = RX_CMD;
          end
        end
        RX_DATA: begin
          if (new_rx_data_i) begin
            wdata_d[int'(idx_q)*8 +: 8] = rx_data_i;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
            csum_d = csum_update(csum_q, rx_data_i);
`endif
            if (idx_q == 8'(DATA_BYTES - 1)) begin
              idx_d   = 8'd0;
              state_d = WRITE;
              we_d    = 1'b1;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else begin
            state_d = RX_DATA;
          end
        end
        WRITE: begin
          addr_d = addr_q + ADDR_W'(1);
          if (count_q == 7'd0) begin
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
            state_d = RX_CSUM;
`else
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q - 7'd1;
            state_d = RX_DATA;
          end
        end
        READ: state_d = READ_WAIT;
        READ_WAIT: begin
          if (lat_q == 3'd0) begin
            rdata_d = ram_rdata_i;
            idx_d   = 8'd0;
            first_d = 1'b0;
            state_d = first_q ? TX_HEADER : TX_DATA;
          end else begin
            lat_d = lat_q - 3'd1;
          end
        end
        TX_HEADER: begin
          if (tx_go_s) begin
            tx_data_d = header_byte_i;
            new_tx_d  = 1'b1;
            guard_d   = 2'd2;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
            state_d   = is_write_q ? TX_STATUS : TX_DATA;
`else
            state_d   = TX_DATA;
`endif
          end else begin
            state_d = TX_HEADER;
          end
        end
        TX_DATA: begin
          if (tx_go_s) begin
            tx_data_d = rdata_q[int'(idx_q)*8 +: 8];
            new_tx_d  = 1'b1;
            guard_d   = 2'd2;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
            csum_d = csum_update(csum_q, rdata_q[int'(idx_q)*8 +: 8]);
`endif
            if (idx_q == 8'(DATA_BYTES - 1)) begin
              idx_d  = 8'd0;
              addr_d = addr_q + ADDR_W'(1);
              if (count_q == 7'd0) begin
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
                state_d = TX_CSUM;
`else
                state_d = IDLE;
`endif
              end else begin
                count_d = count_q - 7'd1;
                state_d = READ;
                re_d    = 1'b1;
                lat_d   = 3'(RD_LATENCY - 1);
              end
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else begin
            state_d = TX_DATA;
          end
        end
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
        RX_CSUM: begin
          if (new_rx_data_i) begin
            csum_ok_d = (rx_data_i == csum_q);
            state_d   = TX_HEADER;
          end else begin
            state_d = RX_CSUM;
          end
        end
        TX_STATUS: begin
          if (tx_go_s) begin
            tx_data_d = csum_ok_q ? ACK_BYTE : NAK_BYTE;
            new_tx_d  = 1'b1;
            guard_d   = 2'd2;
            state_d   = IDLE;
          end else begin
            state_d = TX_STATUS;
          end
        end
        TX_CSUM: begin
          if (tx_go_s) begin
            tx_data_d = csum_q;
            new_tx_d  = 1'b1;
            guard_d   = 2'd2;
            state_d   = IDLE;
          end else begin
            state_d = TX_CSUM;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      count_q   <= 7'd0;
      idx_q     <= 8'd0;
      lat_q     <= 3'd0;
      guard_q   <= 2'd0;
      first_q   <= 1'b0;
      tx_data_q <= 8'd0;
      new_tx_q  <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
      csum_q     <= 8'd0;
      is_write_q <= 1'b0;
      csum_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      lat_q     <= lat_d;
      guard_q   <= guard_d;
      first_q   <= first_d;
      tx_data_q <= tx_data_d;
      new_tx_q  <= new_tx_d;
      we_q      <= we_d;
      re_q      <= re_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
      csum_q     <= csum_d;
      is_write_q <= is_write_d;
      csum_ok_q  <= csum_ok_d;
`endif
    end
  end

  assign tx_data_o     = tx_data_q;
  assign new_tx_data_o = new_tx_q;
  assign ram_addr_o    = addr_q;
  assign ram_wdata_o   = wdata_q;
  assign ram_we_o      = we_q;
  assign ram_re_o      = re_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Scoreboard bench for uart_ram_bridge: random and directed frames against a frame-level model.
module tb_uart_ram_bridge;

  localparam int         RDL = 2;
  localparam int         TO  = 64;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_rx = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data_o;
  logic        new_tx_data_o;
  logic [7:0]  ram_addr_o;
  logic [15:0] ram_wdata_o;
  logic        ram_we_o, ram_re_o, busy_o, timeout_o;
  logic [15:0] ram_rdata = 16'd0;

  uart_ram_bridge #(.ADDR_BYTES(1), .DATA_BYTES(2), .RD_LATENCY(RDL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .new_rx_data_i(new_rx), .rx_data_i(rx_data),
    .header_byte_i(HDR), .tx_busy_i(tx_busy), .tx_data_o(tx_data_o),
    .new_tx_data_o(new_tx_data_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_re_o(ram_re_o), .ram_rdata_i(ram_rdata),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          busy_strobes = 0;
  bit          force_busy = 1'b0;
  logic [15:0] ram [256];
  logic [15:0] ref_mem [256];
  logic [7:0]  exp_tx [$];
  logic [23:0] exp_we [$];
  logic [7:0]  exp_re [$];
  bit          exp_to [$];
  logic [7:0]  frame_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // RAM with RDL-cycle read latency and a UART transmitter busy for a few cycles per byte.
  initial begin
    logic [15:0] pipe [RDL+1];
    int          busy_cnt;
    busy_cnt = 0;
    for (int i = 0; i <= RDL; i++) pipe[i] = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (ram_we_o) ram[ram_addr_o] = ram_wdata_o;
      for (int i = RDL; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = ram_re_o ? ram[ram_addr_o] : 16'hDEAD;
      ram_rdata = pipe[RDL];
      if (new_tx_data_o) busy_cnt = 3;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = force_busy || (busy_cnt != 0);
    end
  end

  // Monitor: every DUT strobe pops and checks the matching expectation.
  initial begin
    logic [7:0]  e8;
    logic [23:0] e24;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (new_tx_data_o) begin
          if (force_busy) busy_strobes++;
          if (exp_tx.size() == 0) chk("tx_unexpected", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
          else begin e8 = exp_tx.pop_front(); chk("tx_byte", {24'd0, tx_data_o}, {24'd0, e8}); end
        end
        if (ram_we_o) begin
          if (exp_we.size() == 0) chk("we_unexpected", {8'd0, ram_addr_o, ram_wdata_o}, 32'hFFFF_FFFF);
          else begin e24 = exp_we.pop_front(); chk("write", {8'd0, ram_addr_o, ram_wdata_o}, {8'd0, e24}); end
        end
        if (ram_re_o) begin
          if (exp_re.size() == 0) chk("re_unexpected", {24'd0, ram_addr_o}, 32'hFFFF_FFFF);
          else begin e8 = exp_re.pop_front(); chk("read_addr", {24'd0, ram_addr_o}, {24'd0, e8}); end
        end
        if (timeout_o) begin
          if (exp_to.size() == 0) chk("timeout_unexpected", 32'd1, 32'd0);
          else void'(exp_to.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    new_rx  = 1'b1;
    @(negedge clk);
    new_rx  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Frame-level model: what the bridge must write, read and transmit for one command.
  task automatic build_frame(input logic [7:0] a, input bit wr, input int n,
                             input logic [15:0] w0, input bit bad_cs);
    logic [7:0]  cmd, cs, rcs, ad;
    logic [15:0] w;
    frame_q.delete();
    cmd = {7'(n - 1), wr};
    frame_q.push_back(HDR);
    frame_q.push_back(a);
    frame_q.push_back(cmd);
    cs  = a ^ cmd;
    rcs = 8'h00;
    for (int i = 0; i < n; i++) begin
      ad = a + 8'(i);
      if (wr) begin
        w = (i == 0) ? w0 : 16'($urandom);
        frame_q.push_back(w[7:0]);
        frame_q.push_back(w[15:8]);
        cs = cs ^ w[7:0] ^ w[15:8];
        exp_we.push_back({ad, w});
        ref_mem[ad] = w;
      end else begin
        w = ref_mem[ad];
        exp_re.push_back(ad);
        if (i == 0) exp_tx.push_back(HDR);
        exp_tx.push_back(w[7:0]);
        exp_tx.push_back(w[15:8]);
        rcs = rcs ^ w[7:0] ^ w[15:8];
      end
    end
`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
    if (wr) begin
      frame_q.push_back(bad_cs ? ~cs : cs);
      exp_tx.push_back(HDR);
      exp_tx.push_back(bad_cs ? 8'h55 : 8'hAA);
    end else begin
      exp_tx.push_back(rcs);
    end
`endif
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i], int'($urandom_range(0, 4)));
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy_o || exp_tx.size() != 0 || exp_we.size() != 0 || exp_re.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_complete"}, 32'(k < 3000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input bit wr, input int n,
                           input logic [15:0] w0, input bit bad_cs);
    build_frame(a, wr, n, w0, bad_cs);
    send_frame();
    wait_idle(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_left;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[8'hFE] = 16'hBEEF; ref_mem[8'hFE] = 16'hBEEF;
    ram[8'hFF] = 16'hCAFE; ref_mem[8'hFF] = 16'hCAFE;
    ram[8'h00] = 16'h1357; ref_mem[8'h00] = 16'h1357;

    repeat (3) @(negedge clk);
    chk("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
    chk("rst_new_tx", {31'd0, new_tx_data_o}, 32'd0);
    chk("rst_addr", {24'd0, ram_addr_o}, 32'd0);
    chk("rst_wdata", {16'd0, ram_wdata_o}, 32'd0);
    chk("rst_strobes", {29'd0, ram_we_o, ram_re_o, timeout_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("write_single", 8'h10, 1'b1, 1, 16'h1234, 1'b0);
    run_frame("read_wrap", 8'hFE, 1'b0, 3, 16'h0000, 1'b0);

    send_byte(HDR, 0);
    chk("busy_after_header", {31'd0, busy_o}, 32'd1);
    send_byte(8'h10, 1);
    send_byte(8'h01, 1);
    send_byte(8'h34, 0);
    repeat (TO - 10) @(negedge clk);
    exp_to.push_back(1'b1);
    for (int k = 0; k < 60 && exp_to.size() != 0; k++) @(negedge clk);
    chk("timeout_pulse", exp_to.size(), 32'd0);
    chk("idle_after_timeout", {31'd0, busy_o}, 32'd0);
    exp_to.delete();
    run_frame("read_after_timeout", 8'h20, 1'b0, 1, 16'h0000, 1'b0);

    @(negedge clk);
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    build_frame(8'h40, 1'b0, 2, 16'h0000, 1'b0);
    exp_left = exp_tx.size();
    send_frame();
    send_byte(HDR, 0);
    send_byte(8'h42, 0);
    repeat (200) @(negedge clk);
    chk("busy_hold_strobes", busy_strobes, 32'd0);
    chk("busy_hold_pending", exp_tx.size(), exp_left);
    force_busy = 1'b0;
    wait_idle("busy_release");

    build_frame(8'h30, 1'b1, 2, 16'h2211, 1'b0);
    frame_q[2] = {7'd3, 1'b1};
    frame_q.push_back(8'h55);
    foreach (frame_q[i]) send_byte(frame_q[i], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {ram_addr_o, ram_wdata_o, tx_data_o}, 32'd0);
    chk("midrst_strobes", {26'd0, ram_we_o, ram_re_o, new_tx_data_o, timeout_o, busy_o, 1'b0}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_writes_done", exp_we.size(), 32'd0);
    exp_tx.delete();
    exp_we.delete();
    exp_re.delete();
    repeat (2) @(negedge clk);
    run_frame("read_after_reset", 8'h30, 1'b0, 2, 16'h0000, 1'b0);

`ifdef UART_RAM_BRIDGE_CHECKSUM_EN
    run_frame("csum_good", 8'h10, 1'b1, 1, 16'h1234, 1'b0);
    run_frame("csum_bad", 8'h10, 1'b1, 1, 16'h1234, 1'b1);
    run_frame("csum_readback", 8'h10, 1'b0, 1, 16'h0000, 1'b0);
`endif

    for (int f = 0; f < 16; f++) begin
      run_frame("random", 8'($urandom), 1'($urandom), int'($urandom_range(1, 4)), 16'($urandom), 1'b0);
    end
    run_frame("random_readback", 8'hFD, 1'b0, 4, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
